// File: rtl/lfsr_rx_checker.sv
// LFSR serial link receiver: deserialises the LSB-first bit stream and checks each word
// against a local model of the generator register. Optional LFSR_CHK_BITERR_EN adds bit_err_cnt.
module lfsr_rx_checker #(
  parameter int           W         = 8,
  parameter logic [W-1:0] TAPS      = 8'b10101010,
  parameter int           ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [W-1:0]         seed,
  input  logic                 load,
  input  logic                 step,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic [W-1:0]         rx_word,
  output logic                 word_done,
  output logic                 match,
  output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef LFSR_CHK_BITERR_EN
  output logic [ERR_CNT_W-1:0] bit_err_cnt,
`endif
  output logic                 proto_err
);

  localparam int CNT_W = $clog2(W);
  localparam int PC_W  = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  typedef enum logic {IDLE, RECV} state_t;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] m);
    logic         fb;
    logic [W-1:0] n;
    fb   = (~|m[W-2:0]) ^ m[W-1];
    n[0] = fb;
    for (int i = 1; i < W; i++) n[i] = m[i-1] ^ (TAPS[i] & fb);
    return n;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                   input logic [PC_W-1:0]      b);
    logic [31:0] sum;
    sum = 32'(a) + 32'(b);
    if (sum > 32'({ERR_CNT_W{1'b1}})) return {ERR_CNT_W{1'b1}};
    return sum[ERR_CNT_W-1:0];
  endfunction

`ifdef LFSR_CHK_BITERR_EN
  function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction
`endif

  state_t           state_p0, state_d;
  logic [CNT_W-1:0] bit_cnt_p0, bit_cnt_d;
  logic [W-1:0]     shift_p0, shift_d;
  logic [W-1:0]     model_p0, model_d;
  logic             complete, proto_set;

  // Stage 0: next-state, capture and model update
  always_comb begin
    state_d   = state_p0;
    bit_cnt_d = bit_cnt_p0;
    shift_d   = shift_p0;
    model_d   = model_p0;
    complete  = 1'b0;
    proto_set = 1'b0;
    if (load) begin
      model_d   = seed;
      shift_d   = '0;
      bit_cnt_d = '0;
      state_d   = IDLE;
    end else begin
      if (step) begin
        if (state_p0 == IDLE && !bit_valid) model_d = lfsr_next(model_p0);
        else                                proto_set = 1'b1;
      end
      if (bit_valid) begin
        shift_d = {bit_in, shift_p0[W-1:1]};
        if (bit_cnt_p0 == LAST_BIT) begin
          // The generator register has been shifted out, so its next steps start from zero.
          complete  = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
          model_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_p0 + CNT_W'(1);
          state_d   = RECV;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p0   <= IDLE;
      bit_cnt_p0 <= '0;
      shift_p0   <= '0;
      model_p0   <= seed;
    end else begin
      state_p0   <= state_d;
      bit_cnt_p0 <= bit_cnt_d;
      shift_p0   <= shift_d;
      model_p0   <= model_d;
    end
  end

  // Stage 1: registered word result and error accounting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_word   <= '0;
      word_done <= 1'b0;
      match     <= 1'b0;
      err_cnt   <= '0;
      proto_err <= 1'b0;
`ifdef LFSR_CHK_BITERR_EN
      bit_err_cnt <= '0;
`endif
    end else begin
      word_done <= complete;
      if (proto_set) proto_err <= 1'b1;
      if (complete) begin
        rx_word <= shift_d;
        match   <= (shift_d == model_p0);
        err_cnt <= sat_add(err_cnt, PC_W'(shift_d != model_p0));
`ifdef LFSR_CHK_BITERR_EN
        bit_err_cnt <= sat_add(bit_err_cnt, popcount(shift_d ^ model_p0));
`endif
      end
    end
  end

endmodule
